fuzz_sig_compactor: RTL and testbench

- Downstream consumer of the fuzz DUT's flattened output bus (out_flat, 159 bits).
- Compacts a programmable window of output words into a 32-bit MISR signature, so a regression compares one word per run instead of a per-cycle text trace.
- Sits between the DUT instance and the run-control logic. Capture is started by a pulse, runs for N valid samples, then presents the signature with a done handshake.

---
 rtl/fuzz_sig_pkg.sv | 19 +
 rtl/fuzz_misr_step.sv | 33 +++
 rtl/fuzz_sig_compactor.sv | 129 ++++++++++++
 tb/tb_fuzz_sig_compactor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_sig_pkg.sv
// Shared types and constants for the output-bus signature compactor.
package fuzz_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  // Width of the data bus after zero-padding up to a whole number of
  // signature-sized chunks.
  function automatic int fold_width(input int data_w, input int sig_w);
    return ((data_w + sig_w - 1) / sig_w) * sig_w;
  endfunction

endpackage

// File: rtl/fuzz_misr_step.sv
// One MISR step: fold the data bus down to SIG_W bits, then shift the
// signature left with polynomial feedback and XOR the fold in.
module fuzz_misr_step
  import fuzz_sig_pkg::*;
#(
  parameter int               DATA_W = 159,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
  input  logic [SIG_W-1:0]  sig_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [SIG_W-1:0]  sig_out
);

  localparam int FOLD_W  = fold_width(DATA_W, SIG_W);
  localparam int N_CHUNK = FOLD_W / SIG_W;

  logic [FOLD_W-1:0] padded;
  logic [SIG_W-1:0]  fold;

  // XOR all chunks of the zero-extended bus, then apply shift and feedback.
  always_comb begin
    padded = FOLD_W'(data_in);
    fold   = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
    sig_out = {sig_in[SIG_W-2:0], 1'b0}
            ^ (sig_in[SIG_W-1] ? POLY : '0)
            ^ fold;
  end

endmodule

// File: rtl/fuzz_sig_compactor.sv
// Compacts a programmable window of valid output-bus samples into a MISR
// signature and reports completion with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; holds last signature, count and sig_valid
//   RUN   | compacting valid samples until the latched count is reached
//   DONE  | single cycle: done=1, signature final, then back to IDLE
module fuzz_sig_compactor
  import fuzz_sig_pkg::*;
#(
  parameter int               DATA_W = 159,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              sig_valid,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sig_valid_q, sig_valid_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [SIG_W-1:0]  sig_next;
  logic [CNT_W-1:0]  cnt_inc;

  fuzz_misr_step #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY)
  ) u_step (
    .sig_in  (sig_q),
    .data_in (data_in),
    .sig_out (sig_next)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output decode for the capture FSM.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sig_valid_d = sig_valid_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_d       = SEED;
          cnt_d       = '0;
          sig_valid_d = 1'b0;
          target_d    = num_cycles;
          state_d     = RUN;
          // An empty window passes through RUN once without sampling, so
          // busy stays low and done lands at the same latency as a
          // one-sample window.
          busy_d      = (num_cycles != '0);
        end
      end
      RUN: begin
        if (target_q == '0) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          sig_valid_d = 1'b1;
        end else if (data_valid) begin
          sig_d = sig_next;
          cnt_d = cnt_inc;
          if (cnt_inc == target_q) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            sig_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sig_valid_q <= 1'b0;
      sig_q       <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sig_valid_q <= sig_valid_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sig_valid    = sig_valid_q;
  assign signature    = sig_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_fuzz_sig_compactor.sv
// Self-checking bench for fuzz_sig_compactor: one instance with SEED=0 and
// one with the default seed share the same stimulus.
module tb_fuzz_sig_compactor;

  localparam int          DATA_W = 159;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED1  = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [15:0]       num_cycles;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;

  logic        busy0, done0, sv0;
  logic [31:0] sig0;
  logic [15:0] cnt0;
  logic        busy1, done1, sv1;
  logic [31:0] sig1;
  logic [15:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] lcg = 32'h1234_5678;

  always #5 clk = ~clk;

  fuzz_sig_compactor #(.SEED(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
    .data_in(data_in), .data_valid(data_valid),
    .busy(busy0), .done(done0), .sig_valid(sv0),
    .signature(sig0), .sample_count(cnt0)
  );

  fuzz_sig_compactor u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
    .data_in(data_in), .data_valid(data_valid),
    .busy(busy1), .done(done1), .sig_valid(sv1),
    .signature(sig1), .sample_count(cnt1)
  );

  // Reference: every data bit lands in fold bit (index mod 32), then a
  // standard left-shifting MISR with polynomial feedback.
  function automatic logic [31:0] ref_step(input logic [31:0] s,
                                           input logic [DATA_W-1:0] d);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < DATA_W; i++) f[i % 32] = f[i % 32] ^ d[i];
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [DATA_W-1:0] lcg_data();
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < 5; i++) begin
      lcg = lcg * 32'd1664525 + 32'd1013904223;
      d = (d << 32) | DATA_W'(lcg);
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_cycles = '0; data_in = '0; data_valid = 1'b0;
    tick(); tick();
    n_tests++;
    if ({busy0, done0, sv0, sig0, cnt0} !== '0) begin
      n_fail++; $display("FAIL reset_dut0 got busy=%0b done=%0b sv=%0b sig=%h cnt=%0d want all 0",
                         busy0, done0, sv0, sig0, cnt0);
    end
    n_tests++;
    if ({busy1, done1, sv1, sig1, cnt1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1 got busy=%0b done=%0b sv=%0b sig=%h cnt=%0d want all 0",
                         busy1, done1, sv1, sig1, cnt1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    start = 1'b1; num_cycles = 16'd1; data_in = DATA_W'(1); data_valid = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 16'd0) begin
      n_fail++; $display("FAIL single_accept got busy=%0b done=%0b cnt=%0d want 1 0 0", busy0, done0, cnt0);
    end
    tick();
    data_valid = 1'b0;
    n_tests++;
    if (done0 !== 1'b1 || sig0 !== 32'h1 || cnt0 !== 16'd1 || sv0 !== 1'b1 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL single_done got done=%0b sig=%h cnt=%0d sv=%0b busy=%0b want 1 00000001 1 1 0",
                         done0, sig0, cnt0, sv0, busy0);
    end
    tick();
    n_tests++;
    if (done0 !== 1'b0 || sv0 !== 1'b1 || sig0 !== 32'h1) begin
      n_fail++; $display("FAIL single_hold got done=%0b sv=%0b sig=%h want 0 1 00000001", done0, sv0, sig0);
    end
  endtask

  task automatic test_gap();
    start = 1'b1; num_cycles = 16'd2; data_valid = 1'b0;
    tick();
    start = 1'b0;
    n_tests++;
    if (sv0 !== 1'b0 || sig0 !== 32'h0) begin
      n_fail++; $display("FAIL gap_rearm got sv=%0b sig=%h want 0 00000000", sv0, sig0);
    end
    data_in = DATA_W'(1); data_valid = 1'b1;
    tick();
    data_in = lcg_data(); data_valid = 1'b0;
    tick();
    n_tests++;
    if (sig0 !== 32'h1 || cnt0 !== 16'd1 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL gap_hold got sig=%h cnt=%0d done=%0b want 00000001 1 0", sig0, cnt0, done0);
    end
    data_in = '0; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n_tests++;
    if (sig0 !== 32'h2 || cnt0 !== 16'd2 || done0 !== 1'b1) begin
      n_fail++; $display("FAIL gap_done got sig=%h cnt=%0d done=%0b want 00000002 2 1", sig0, cnt0, done0);
    end
    tick();
  endtask

  task automatic test_feedback();
    start = 1'b1; num_cycles = 16'd1; data_valid = 1'b0;
    tick();
    start = 1'b0; data_in = '0; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n_tests++;
    if (sig1 !== 32'hFB3EE249 || done1 !== 1'b1) begin
      n_fail++; $display("FAIL feedback got sig=%h done=%0b want fb3ee249 1", sig1, done1);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; data_in = '0; data_in[0] = 1'b1; data_in[32] = 1'b1; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n_tests++;
    if (sig0 !== 32'h0 || done0 !== 1'b1) begin
      n_fail++; $display("FAIL fold_cancel got sig=%h done=%0b want 00000000 1", sig0, done0);
    end
    tick();
  endtask

  task automatic test_zero_window();
    start = 1'b1; num_cycles = 16'd0; data_valid = 1'b1; data_in = lcg_data();
    tick();
    start = 1'b0;
    n_tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL zero_cycle1 got done=%0b busy=%0b want 0 0", done1, busy1);
    end
    tick();
    data_valid = 1'b0;
    n_tests++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || sig1 !== SEED1 || cnt1 !== 16'd0 || sv1 !== 1'b1) begin
      n_fail++; $display("FAIL zero_done got done=%0b busy=%0b sig=%h cnt=%0d sv=%0b want 1 0 ffffffff 0 1",
                         done1, busy1, sig1, cnt1, sv1);
    end
    n_tests++;
    if (done0 !== 1'b1 || sig0 !== 32'h0 || cnt0 !== 16'd0) begin
      n_fail++; $display("FAIL zero_done_seed0 got done=%0b sig=%h cnt=%0d want 1 00000000 0", done0, sig0, cnt0);
    end
    tick();
    n_tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL zero_after got done=%0b busy=%0b want 0 0", done1, busy1);
    end
  endtask

  task automatic test_start_mid_run();
    logic [31:0] m_sig;
    m_sig = SEED1;
    start = 1'b1; num_cycles = 16'd5; data_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = lcg_data(); data_valid = 1'b1;
      start = (i == 2); num_cycles = (i == 2) ? 16'd1 : 16'd5;
      tick();
      m_sig = ref_step(m_sig, data_in);
      if (i < 4) begin
        n_tests++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || cnt1 !== 16'(i + 1)) begin
          n_fail++; $display("FAIL midrun_start_step%0d got done=%0b busy=%0b cnt=%0d want 0 1 %0d",
                             i, done1, busy1, cnt1, i + 1);
        end
      end
    end
    start = 1'b0; data_valid = 1'b0;
    n_tests++;
    if (done1 !== 1'b1 || cnt1 !== 16'd5 || sig1 !== m_sig) begin
      n_fail++; $display("FAIL midrun_start_done got done=%0b cnt=%0d sig=%h want 1 5 %h", done1, cnt1, sig1, m_sig);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int saw_done;
    start = 1'b1; num_cycles = 16'd10; data_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = lcg_data(); data_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (busy1 !== 1'b0 || sig1 !== 32'h0 || cnt1 !== 16'd0 || done1 !== 1'b0 || sv1 !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset got busy=%0b sig=%h cnt=%0d done=%0b sv=%0b want 0 0 0 0 0",
                         busy1, sig1, cnt1, done1, sv1);
    end
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1 === 1'b1 || busy1 === 1'b1) saw_done = 1;
    end
    data_valid = 1'b0;
    n_tests++;
    if (saw_done != 0) begin
      n_fail++; $display("FAIL midrun_reset_quiet got done/busy activity=%0d want 0", saw_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_sig;
    int          m_cnt;
    start = 1'b1; num_cycles = 16'd100; data_valid = 1'b0;
    tick();
    start = 1'b0;
    m_sig = SEED1;
    m_cnt = 0;
    for (int cyc = 0; cyc < 2000 && m_cnt < 100; cyc++) begin
      data_in    = lcg_data();
      data_valid = ($urandom_range(0, 3) != 0);
      tick();
      if (data_valid) begin
        m_sig = ref_step(m_sig, data_in);
        m_cnt++;
      end
      n_tests++;
      if (sig1 !== m_sig || cnt1 !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL random_sig cyc=%0d got sig=%h cnt=%0d want %h %0d", cyc, sig1, cnt1, m_sig, m_cnt);
      end
      n_tests++;
      if (done1 !== (data_valid && m_cnt == 100)) begin
        n_fail++; $display("FAIL random_done cyc=%0d got %0b want %0b", cyc, done1, (data_valid && m_cnt == 100));
      end
    end
    data_valid = 1'b0;
    n_tests++;
    if (m_cnt != 100) begin
      n_fail++; $display("FAIL random_timeout got %0d samples want 100", m_cnt);
    end
    tick();
    n_tests++;
    if (sv1 !== 1'b1 || sig1 !== m_sig) begin
      n_fail++; $display("FAIL random_hold got sv=%0b sig=%h want 1 %h", sv1, sig1, m_sig);
    end
    // back-to-back re-arm from IDLE while sig_valid is still set
    start = 1'b1; num_cycles = 16'd3;
    tick();
    start = 1'b0;
    n_tests++;
    if (sv1 !== 1'b0 || sig1 !== SEED1 || cnt1 !== 16'd0 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL rearm got sv=%0b sig=%h cnt=%0d busy=%0b want 0 ffffffff 0 1", sv1, sig1, cnt1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_feedback();
    test_zero_window();
    test_start_mid_run();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
